// File: rtl/dct8_pipe.sv
// dct8_pipe: unscaled 8-point fast DCT (AAN flow), 7 stages + output register.
// Ports: clk, reset (sync, active-low), in_valid/in_ready/in_data/in_tag,
//        out_valid/out_ready/out_data/out_tag, busy (any stage holds a beat).
module dct8_pipe #(
    parameter int W     = 22,
    parameter int FRAC  = 8,
    parameter int ROUND = 1,
    parameter int SAT   = 1,
    parameter int TAGW  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [8*W-1:0]    in_data,
    input  logic [TAGW-1:0]   in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [8*W-1:0]    out_data,
    output logic [TAGW-1:0]   out_tag,
    output logic              busy
);

    localparam int SW = W + 3;
    localparam int CW = FRAC + 3;
    localparam int PW = SW + CW;

    localparam real SC  = $itor(1 << FRAC);
    localparam int  A1I = $rtoi(0.7071067811865476 * SC + 0.5);
    localparam int  A2I = $rtoi(0.5411961001461970 * SC + 0.5);
    localparam int  A4I = $rtoi(1.3065629648763766 * SC + 0.5);
    localparam int  A5I = $rtoi(0.3826834323650898 * SC + 0.5);

    localparam logic signed [CW-1:0] A1 = CW'(A1I);
    localparam logic signed [CW-1:0] A2 = CW'(A2I);
    localparam logic signed [CW-1:0] A4 = CW'(A4I);
    localparam logic signed [CW-1:0] A5 = CW'(A5I);

    localparam longint RCI = (ROUND != 0) ? (64'sd1 <<< (FRAC - 1)) : 64'sd0;

    localparam logic signed [SW-1:0] MAXV = {4'b0000, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {4'b1111, {(W-1){1'b0}}};

    // Fixed-point multiply: widen, add rounding bias, arithmetic shift back.
    function automatic logic signed [SW-1:0] mulc(
        input logic signed [SW-1:0] v,
        input logic signed [CW-1:0] a
    );
        logic signed [PW-1:0] p;
        p = PW'(v) * PW'(a) + PW'(RCI);
        return SW'(p >>> FRAC);
    endfunction

    function automatic logic [W-1:0] clip(input logic signed [SW-1:0] v);
        logic [W-1:0] r;
        r = v[W-1:0];
        if (SAT != 0) begin
            if (v > MAXV)
                r = MAXV[W-1:0];
            else if (v < MINV)
                r = MINV[W-1:0];
        end
        return r;
    endfunction

    logic                 adv;
    logic [7:1]           vld;
    logic [TAGW-1:0]      tg [1:7];

    logic signed [SW-1:0] xe [8];
    logic signed [SW-1:0] a [8];
    logic signed [SW-1:0] b7, b8, b9, b10, b11, b12, b13, b14;
    logic signed [SW-1:0] c7, c11, c12, c13, c14, c15, c16, c17, cd;
    logic signed [SW-1:0] d5, d7, d11, d12, d13, d14, d15, d16, d17;
    logic signed [SW-1:0] e7, e13, e15, e16, e19, e20, e21, e22;
    logic signed [SW-1:0] f15, f16, f19, f20, f21, f22, f23, f24;
    logic signed [SW-1:0] g [8];
    logic [8*W-1:0]       od;

    // All stages move together; a stalled output freezes the whole pipe.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign busy     = (|vld) | out_valid;

    always_comb begin
        for (int i = 0; i < 8; i++)
            xe[i] = SW'($signed(in_data[i*W +: W]));
    end

    always_comb begin
        od = '0;
        for (int i = 0; i < 8; i++)
            od[i*W +: W] = clip(g[i]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            vld       <= {vld[6:1], in_valid};
            out_valid <= vld[7];
            if (vld[7]) begin
                out_data <= od;
                out_tag  <= tg[7];
            end
        end
    end

    // Datapath is not reset: contents only matter while the valid bit is set.
    always_ff @(posedge clk) begin
        if (adv) begin
            tg[1] <= in_tag;
            for (int i = 2; i <= 7; i++)
                tg[i] <= tg[i-1];

            a[0] <= xe[0] + xe[7];
            a[1] <= xe[1] + xe[6];
            a[2] <= xe[2] + xe[5];
            a[3] <= xe[3] + xe[4];
            a[4] <= xe[3] - xe[4];
            a[5] <= xe[2] - xe[5];
            a[6] <= xe[1] - xe[6];
            a[7] <= xe[0] - xe[7];

            b8  <= a[0] + a[3];
            b9  <= a[1] + a[2];
            b10 <= a[1] - a[2];
            b11 <= a[0] - a[3];
            b12 <= a[4] + a[5];
            b13 <= a[5] + a[6];
            b14 <= a[6] + a[7];
            b7  <= a[7];

            c15 <= b8 + b9;
            c16 <= b8 - b9;
            c17 <= mulc(b10 + b11, A1);
            c11 <= b11;
            c12 <= mulc(b12, A2);
            c14 <= mulc(b14, A4);
            cd  <= b14 - b12;
            c13 <= b13;
            c7  <= b7;

            d15 <= c15;
            d16 <= c16;
            d17 <= c17;
            d11 <= c11;
            d12 <= c12;
            d14 <= c14;
            d5  <= mulc(cd, A5);
            d13 <= c13;
            d7  <= c7;

            e15 <= d15;
            e16 <= d16;
            e21 <= d17 + d11;
            e22 <= d11 - d17;
            e19 <= d12 - d5;
            e20 <= d14 - d5;
            e13 <= mulc(d13, A1);
            e7  <= d7;

            f15 <= e15;
            f16 <= e16;
            f21 <= e21;
            f22 <= e22;
            f19 <= e19;
            f20 <= e20;
            f23 <= e13 + e7;
            f24 <= e7 - e13;

            // Odd outputs reordered into natural coefficient order here.
            g[0] <= f15;
            g[1] <= f23 + f20;
            g[2] <= f21;
            g[3] <= f24 - f19;
            g[4] <= f16;
            g[5] <= f19 + f24;
            g[6] <= f22;
            g[7] <= f23 - f20;
        end
    end

endmodule

// File: tb/tb_dct8_pipe.sv
// tb_dct8_pipe: scoreboard bench for dct8_pipe with default parameters.
// Expected rows come from an integer model of the unscaled AAN flow.
module tb_dct8_pipe;

    localparam int W    = 22;
    localparam int FRAC = 8;
    localparam int TAGW = 4;
    localparam int DW   = 8 * W;
    localparam longint MAXP = (64'sd1 <<< (W - 1)) - 1;
    localparam longint MINP = -(64'sd1 <<< (W - 1));

    typedef logic [DW+TAGW-1:0] ent_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_data = '0;
    logic [TAGW-1:0] in_tag = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   out_data;
    logic [TAGW-1:0] out_tag;
    logic            busy;

    int   checks = 0;
    int   failures = 0;
    ent_t exp_q[$];

    dct8_pipe #(
        .W(W), .FRAC(FRAC), .ROUND(1), .SAT(1), .TAGW(TAGW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_tag(in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_tag(out_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic longint mul(input longint v, input longint c);
        return (v * c + 128) >>> FRAC;
    endfunction

    function automatic logic [W-1:0] sat(input longint v);
        longint r;
        r = v;
        if (r > MAXP) r = MAXP;
        if (r < MINP) r = MINP;
        return W'(r);
    endfunction

    function automatic logic [DW-1:0] dct_model(input logic [DW-1:0] d);
        longint x[8];
        longint v0, v1, v2, v3, v4, v5, v6, v7;
        longint v8, v9, v10, v11, u12, v14;
        longint m13, m17, m18, v19, v20, v21, v22, v23, v24;
        logic [DW-1:0] r;
        for (int i = 0; i < 8; i++)
            x[i] = longint'($signed(d[i*W +: W]));
        v0 = x[0] + x[7]; v1 = x[1] + x[6];
        v2 = x[2] + x[5]; v3 = x[3] + x[4];
        v4 = x[3] - x[4]; v5 = x[2] - x[5];
        v6 = x[1] - x[6]; v7 = x[0] - x[7];
        v8 = v0 + v3; v9 = v1 + v2;
        v10 = v1 - v2; v11 = v0 - v3;
        u12 = v4 + v5; v14 = v6 + v7;
        m13 = mul(v5 + v6, 181);
        m17 = mul(v10 + v11, 181);
        m18 = mul(v14 - u12, 98);
        v19 = mul(u12, 139) - m18;
        v20 = mul(v14, 334) - m18;
        v21 = m17 + v11; v22 = v11 - m17;
        v23 = m13 + v7;  v24 = v7 - m13;
        r = '0;
        r[0*W +: W] = sat(v8 + v9);
        r[1*W +: W] = sat(v23 + v20);
        r[2*W +: W] = sat(v21);
        r[3*W +: W] = sat(v24 - v19);
        r[4*W +: W] = sat(v8 - v9);
        r[5*W +: W] = sat(v19 + v24);
        r[6*W +: W] = sat(v22);
        r[7*W +: W] = sat(v23 - v20);
        return r;
    endfunction

    function automatic logic [DW-1:0] pk(
        input int a0, input int a1, input int a2, input int a3,
        input int a4, input int a5, input int a6, input int a7
    );
        return {W'(a7), W'(a6), W'(a5), W'(a4),
                W'(a3), W'(a2), W'(a1), W'(a0)};
    endfunction

    function automatic logic [DW-1:0] rnd_row();
        logic [DW-1:0] r;
        int s;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            s = int'($urandom_range(2097151, 0)) - 1048576;
            r[i*W +: W] = W'(s);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs; record the expected result if accepted.
    task automatic drive(
        input logic iv, input logic [DW-1:0] d,
        input logic [TAGW-1:0] t, input logic ordy
    );
        in_valid  = iv;
        in_data   = d;
        in_tag    = t;
        out_ready = ordy;
        #1;
        if (iv && in_ready)
            exp_q.push_back({dct_model(d), t});
    endtask

    task automatic wait_out(input int max, output int lat);
        lat = -1;
        for (int n = 1; n <= max; n++) begin
            tick();
            drive(1'b0, '0, '0, 1'b1);
            if (out_valid) begin
                lat = n;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, rnd_row(), 4'd3, 1'b0);
        tick();
        tick();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        checks++;
        if (out_data !== '0) begin
            failures++;
            $display("FAIL reset_out_data got=%h exp=0", out_data);
        end
        checks++;
        if (out_tag !== '0) begin
            failures++;
            $display("FAIL reset_out_tag got=%h exp=0", out_tag);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        tick();
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b1);
        exp_q.delete();
    endtask

    // Single beat with an explicit expected row and tag.
    task automatic test_single(
        input string nm, input logic [DW-1:0] row,
        input logic [TAGW-1:0] t, input logic [DW-1:0] expd
    );
        int   lat;
        ent_t e;
        tick();
        drive(1'b1, row, t, 1'b1);
        wait_out(20, lat);
        checks++;
        if (lat !== 8) begin
            failures++;
            $display("FAIL %s_latency got=%0d exp=8", nm, lat);
        end
        if (lat > 0) begin
            checks++;
            if (out_data !== expd) begin
                failures++;
                $display("FAIL %s_data got=%h exp=%h", nm, out_data, expd);
            end
            checks++;
            if (out_tag !== t) begin
                failures++;
                $display("FAIL %s_tag got=%h exp=%h", nm, out_tag, t);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL %s_model got=empty exp=entry", nm);
            end else begin
                e = exp_q.pop_front();
                if ({out_data, out_tag} !== e) begin
                    failures++;
                    $display("FAIL %s_model got=%h exp=%h", nm,
                             {out_data, out_tag}, e);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] rows[8];
        int   first, last, nout;
        ent_t e;
        first = -1; last = -1; nout = 0;
        for (int i = 0; i < 8; i++)
            rows[i] = rnd_row();
        for (int cyc = 0; cyc < 30; cyc++) begin
            tick();
            drive(cyc < 8, (cyc < 8) ? rows[cyc] : '0, TAGW'(cyc), 1'b1);
            if (cyc < 8) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_in_ready cyc=%0d got=%b exp=1",
                             cyc, in_ready);
                end
            end
            if (out_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
                nout++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_data got=%h exp=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_data, out_tag} !== e) begin
                        failures++;
                        $display("FAIL b2b_data got=%h exp=%h",
                                 {out_data, out_tag}, e);
                    end
                end
            end
        end
        checks++;
        if (first !== 8 || last !== 15 || nout !== 8) begin
            failures++;
            $display("FAIL b2b_timing got=%0d/%0d/%0d exp=8/15/8",
                     first, last, nout);
        end
        exp_q.delete();
    endtask

    task automatic test_stream();
        logic [DW-1:0]   rows[20];
        logic [DW-1:0]   hd;
        logic [TAGW-1:0] ht;
        logic            hv, ordy, iv;
        int   sent, got;
        ent_t e;
        sent = 0; got = 0; hv = 1'b0; hd = '0; ht = '0;
        for (int i = 0; i < 20; i++)
            rows[i] = rnd_row();
        for (int cyc = 0; cyc < 300 && got < 20; cyc++) begin
            tick();
            ordy = !(cyc >= 12 && cyc < 17) && (cyc % 6 != 4);
            iv   = (sent < 20) && (cyc % 9 != 7);
            drive(iv, rows[(sent < 20) ? sent : 0], TAGW'(sent), ordy);
            if (iv && in_ready) sent++;
            if (hv) begin
                checks++;
                if (!out_valid || out_data !== hd || out_tag !== ht) begin
                    failures++;
                    $display("FAIL stall_hold got=%b/%h exp=1/%h",
                             out_valid, out_data, hd);
                end
            end
            hv = out_valid && !out_ready;
            hd = out_data;
            ht = out_tag;
            if (hv) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_in_ready got=%b exp=0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL stream_data got=%h exp=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_data, out_tag} !== e) begin
                        failures++;
                        $display("FAIL stream_data got=%h exp=%h",
                                 {out_data, out_tag}, e);
                    end
                end
            end
        end
        checks++;
        if (sent !== 20 || got !== 20 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL stream_count got=%0d/%0d/%0d exp=20/20/0",
                     sent, got, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_flight();
        int   lat, spurious;
        ent_t e;
        for (int i = 0; i < 4; i++) begin
            tick();
            drive(1'b1, rnd_row(), TAGW'(i), 1'b1);
        end
        tick();
        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b1);
        tick();
        reset = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flight_reset got=%b%b%b exp=001",
                     out_valid, busy, in_ready);
        end
        spurious = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            drive(1'b0, '0, '0, 1'b1);
            if (out_valid || busy) spurious++;
        end
        checks++;
        if (spurious !== 0) begin
            failures++;
            $display("FAIL flight_flush got=%0d exp=0", spurious);
        end
        tick();
        drive(1'b1, rnd_row(), 4'd11, 1'b1);
        wait_out(20, lat);
        checks++;
        if (lat !== 8) begin
            failures++;
            $display("FAIL flight_latency got=%0d exp=8", lat);
        end
        if (lat > 0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL flight_data got=%h exp=none", out_data);
            end else begin
                e = exp_q.pop_front();
                if ({out_data, out_tag} !== e) begin
                    failures++;
                    $display("FAIL flight_data got=%h exp=%h",
                             {out_data, out_tag}, e);
                end
            end
            tick();
            drive(1'b0, '0, '0, 1'b1);
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL flight_busy_fall got=%b%b exp=00",
                         busy, out_valid);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        int mx, mn;
        mx = int'(MAXP);
        mn = int'(MINP);
        test_reset();
        test_single("dc", pk(256, 256, 256, 256, 256, 256, 256, 256), 4'd5,
                    pk(2048, 0, 0, 0, 0, 0, 0, 0));
        test_single("impulse", pk(256, 0, 0, 0, 0, 0, 0, 0), 4'd9,
                    pk(256, 492, 437, 354, 256, 158, 75, 20));
        test_single("sat_max", pk(mx, mx, mx, mx, mx, mx, mx, mx), 4'd1,
                    pk(mx, 0, 0, 0, 0, 0, 0, 0));
        test_single("sat_min", pk(mn, mn, mn, mn, mn, mn, mn, mn), 4'd2,
                    pk(mn, 0, 0, 0, 0, 0, 0, 0));
        test_back_to_back();
        test_stream();
        test_reset_flight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
